// File: rtl/system_client1_cpu_mult_seq.sv
// Sequencing initiator for the CPU partial-product multiplier cell: one or two
// cell passes per request, then 32-bit result assembly with signed correction.
module system_client1_cpu_mult_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PASS1 = 3'd1,
        S_WAIT1 = 3'd2,
        S_PASS2 = 3'd3,
        S_WAIT2 = 3'd4,
        S_RESP  = 3'd5
    } state_e;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;
    localparam logic [1:0] WAIT_INIT = 2'(CELL_LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] p1_q, p1_d;
    logic [31:0] p2_q, p2_d;
    logic [31:0] p3_q, p3_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        req_ready_q, req_ready_d;
    logic        cell_en_q, cell_en_d;
    logic [31:0] cell_src1_q, cell_src1_d;
    logic [31:0] cell_src2_q, cell_src2_d;

    function automatic logic [31:0] low_word(
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] p3
    );
        logic [31:0] mid;
        mid = p2 + p3;
        return p1 + (mid << 16);
    endfunction

    // Unsigned 64-bit sum of the four partials, then sign corrections on the high word.
    function automatic logic [31:0] high_word(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] p3,
        input logic [31:0] p4
    );
        logic [63:0] mid;
        logic [63:0] full;
        logic [31:0] hi;
        mid  = {32'h0000_0000, p2} + {32'h0000_0000, p3};
        full = {32'h0000_0000, p1} + (mid << 16) + {p4, 32'h0000_0000};
        hi   = full[63:32];
        if (((op == OP_MULXSU) || (op == OP_MULXSS)) && a[31]) begin
            hi = hi - b;
        end else begin
            hi = hi;
        end
        if ((op == OP_MULXSS) && b[31]) begin
            hi = hi - a;
        end else begin
            hi = hi;
        end
        return hi;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        wait_d      = wait_q;
        rsp_data_d  = rsp_data_q;
        cell_src1_d = cell_src1_q;
        cell_src2_d = cell_src2_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    src1_d      = req_src1;
                    src2_d      = req_src2;
                    cell_src1_d = req_src1;
                    cell_src2_d = req_src2;
                    state_d     = S_PASS1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PASS1: begin
                wait_d  = WAIT_INIT;
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (wait_q == 2'd0) begin
                    p1_d = cell_p1;
                    p2_d = cell_p2;
                    p3_d = cell_p3;
                    if (op_q == OP_MUL) begin
                        rsp_data_d = low_word(cell_p1, cell_p2, cell_p3);
                        state_d    = S_RESP;
                    end else begin
                        cell_src1_d = {16'h0000, src1_q[31:16]};
                        cell_src2_d = {16'h0000, src2_q[31:16]};
                        state_d     = S_PASS2;
                    end
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_PASS2: begin
                wait_d  = WAIT_INIT;
                state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (wait_q == 2'd0) begin
                    rsp_data_d = high_word(op_q, src1_q, src2_q, p1_q, p2_q, p3_q, cell_p1);
                    state_d    = S_RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake and cell strobes are registered copies of the next state.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        cell_en_d   = (state_d == S_PASS1) || (state_d == S_PASS2);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            src1_q      <= 32'h0000_0000;
            src2_q      <= 32'h0000_0000;
            p1_q        <= 32'h0000_0000;
            p2_q        <= 32'h0000_0000;
            p3_q        <= 32'h0000_0000;
            wait_q      <= 2'd0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            cell_en_q   <= 1'b0;
            cell_src1_q <= 32'h0000_0000;
            cell_src2_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
            wait_q      <= wait_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            cell_en_q   <= cell_en_d;
            cell_src1_q <= cell_src1_d;
            cell_src2_q <= cell_src2_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign cell_en   = cell_en_q;
    assign cell_src1 = cell_src1_q;
    assign cell_src2 = cell_src2_q;

endmodule

// File: tb/tb_system_client1_cpu_mult_seq.sv
// Bench: two sequencers (cell latency 1 and 2), each with a behavioural cell,
// checked against a plain 64-bit arithmetic model of the four multiply ops.
module tb_system_client1_cpu_mult_seq;

    logic        clk;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op    [2];
    logic [31:0] req_src1  [2];
    logic [31:0] req_src2  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic [31:0] cell_src1 [2];
    logic [31:0] cell_src2 [2];
    logic        cell_en   [2];
    logic [31:0] cell_p1   [2];
    logic [31:0] cell_p2   [2];
    logic [31:0] cell_p3   [2];

    logic [31:0] st1_p1 [2], st1_p2 [2], st1_p3 [2];
    logic [31:0] st2_p1 [2], st2_p2 [2], st2_p3 [2];

    int checks   = 0;
    int failures = 0;

    system_client1_cpu_mult_seq #(.CELL_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_src1(req_src1[0]), .req_src2(req_src2[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .cell_src1(cell_src1[0]), .cell_src2(cell_src2[0]), .cell_en(cell_en[0]),
        .cell_p1(cell_p1[0]), .cell_p2(cell_p2[0]), .cell_p3(cell_p3[0])
    );

    system_client1_cpu_mult_seq #(.CELL_LATENCY(2)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_src1(req_src1[1]), .req_src2(req_src2[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .cell_src1(cell_src1[1]), .cell_src2(cell_src2[1]), .cell_en(cell_en[1]),
        .cell_p1(cell_p1[1]), .cell_p2(cell_p2[1]), .cell_p3(cell_p3[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier cell: products sampled on cell_en, then an optional extra stage.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cell_en[d] === 1'b1) begin
                st1_p1[d] <= {16'h0000, cell_src1[d][15:0]}  * {16'h0000, cell_src2[d][15:0]};
                st1_p2[d] <= {16'h0000, cell_src1[d][15:0]}  * {16'h0000, cell_src2[d][31:16]};
                st1_p3[d] <= {16'h0000, cell_src1[d][31:16]} * {16'h0000, cell_src2[d][15:0]};
            end
            st2_p1[d] <= st1_p1[d];
            st2_p2[d] <= st1_p2[d];
            st2_p3[d] <= st1_p3[d];
        end
    end

    assign cell_p1[0] = st1_p1[0];
    assign cell_p2[0] = st1_p2[0];
    assign cell_p3[0] = st1_p3[0];
    assign cell_p1[1] = st2_p1[1];
    assign cell_p2[1] = st2_p2[1];
    assign cell_p3[1] = st2_p3[1];

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, prod;
        ea = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0000_0000, a};
        eb = ((op == 2'b11) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0000_0000, b};
        prod = ea * eb;
        return (op == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    task automatic do_txn(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold,
                          input bit pend, input string tag);
        int lat, exp_lat, k, en_cnt, first, second;
        logic [31:0] c1a, c1b, c2a, c2b;
        lat = d + 1;
        exp_lat = (op == 2'b00) ? 2 + lat : 3 + 2 * lat;
        en_cnt = 0; first = 0; second = 0;
        c1a = 32'h0; c1b = 32'h0; c2a = 32'h0; c2b = 32'h0;
        @(negedge clk);
        req_valid[d] = 1'b1; req_op[d] = op; req_src1[d] = a; req_src2[d] = b;
        rsp_ready[d] = (hold == 0);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            failures++; $display("FAIL %s[%0d] req_ready at request: got %b want 1", tag, d, req_ready[d]);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        k = 1;
        while (rsp_valid[d] !== 1'b1 && k < 30) begin
            if (cell_en[d] === 1'b1) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    first = k; c1a = cell_src1[d]; c1b = cell_src2[d];
                end else begin
                    second = k; c2a = cell_src1[d]; c2b = cell_src2[d];
                end
            end
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k != exp_lat) begin
            failures++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, d, k, exp_lat);
        end
        checks++;
        if (rsp_data[d] !== exp) begin
            failures++; $display("FAIL %s[%0d] data: got %h want %h", tag, d, rsp_data[d], exp);
        end
        checks++;
        if (en_cnt != ((op == 2'b00) ? 1 : 2) || first != 1 || c1a !== a || c1b !== b) begin
            failures++;
            $display("FAIL %s[%0d] pass1: pulses %0d at %0d src %h/%h want at 1 src %h/%h",
                     tag, d, en_cnt, first, c1a, c1b, a, b);
        end
        if (op != 2'b00) begin
            checks++;
            if (second != 2 + lat || c2a !== {16'h0000, a[31:16]} || c2b !== {16'h0000, b[31:16]}) begin
                failures++;
                $display("FAIL %s[%0d] pass2: at %0d src %h/%h want at %0d src %h/%h", tag, d,
                         second, c2a, c2b, 2 + lat, {16'h0000, a[31:16]}, {16'h0000, b[31:16]});
            end
        end
        if (hold > 0) begin
            if (pend) begin
                req_valid[d] = 1'b1; req_op[d] = 2'b00;
                req_src1[d] = $urandom; req_src2[d] = $urandom;
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                checks++;
                if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== exp || req_ready[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s[%0d] stall: valid %b data %h ready %b want 1 %h 0",
                             tag, d, rsp_valid[d], rsp_data[d], req_ready[d], exp);
                end
            end
            @(negedge clk);
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s[%0d] after handshake: valid %b ready %b want 0 1",
                     tag, d, rsp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) reset[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_data[d] !== 32'h0 || cell_en[d] !== 1'b0 ||
                cell_src1[d] !== 32'h0 || cell_src2[d] !== 32'h0 || req_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset[%0d]: valid %b data %h en %b src %h/%h ready %b", d,
                         rsp_valid[d], rsp_data[d], cell_en[d], cell_src1[d], cell_src2[d], req_ready[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) reset[d] = 1'b0;
    endtask

    task automatic test_mul(input int d);
        do_txn(d, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0, 1'b0, "mul");
    endtask

    task automatic test_mulxuu(input int d);
        do_txn(d, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0, "mulxuu");
    endtask

    task automatic test_signed(input int d);
        do_txn(d, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, "mulxss_m1");
        do_txn(d, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulxsu_m1");
        do_txn(d, 2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 0, 1'b0, "mulxss_min");
        do_txn(d, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, "mul_m1");
        do_txn(d, 2'b00, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 0, 1'b0, "mul_min");
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        do_txn(d, 2'b01, a, b, ref_result(2'b01, a, b), 3, 1'b1, "bp_first");
        a = $urandom; b = $urandom;
        do_txn(d, 2'b11, a, b, ref_result(2'b11, a, b), 0, 1'b0, "bp_second");
    endtask

    task automatic test_reset_abort(input int d);
        int seen;
        @(negedge clk);
        req_valid[d] = 1'b1; req_op[d] = 2'b11;
        req_src1[d] = 32'h8765_4321; req_src2[d] = 32'hFEDC_BA98; rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        repeat (3 + d) @(posedge clk);
        #1;
        reset[d] = 1'b1;
        @(posedge clk); #1;
        reset[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || cell_en[d] !== 1'b0) begin
            failures++;
            $display("FAIL abort[%0d]: valid %b ready %b en %b want 0 1 0", d,
                     rsp_valid[d], req_ready[d], cell_en[d]);
        end
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid[d] === 1'b1 || cell_en[d] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL abort_quiet[%0d]: activity cycles got %0d want 0", d, seen);
        end
        do_txn(d, 2'b00, 32'd7, 32'd6, 32'h0000_002A, 0, 1'b0, "post_abort");
    endtask

    task automatic test_random(input int d);
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            if (i % 5 == 0) a = {a[31], 31'h0};
            if (i % 7 == 0) b = 32'hFFFF_FFFF;
            do_txn(d, op, a, b, ref_result(op, a, b), int'($urandom_range(0, 2)), 1'b0, "random");
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_op[d] = 2'b00;
            req_src1[d] = 32'h0; req_src2[d] = 32'h0; rsp_ready[d] = 1'b0;
        end
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_mul(d);
            test_mulxuu(d);
            test_signed(d);
            test_back_to_back(d);
            test_reset_abort(d);
            test_random(d);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/system_client1_cpu_mult_seq.md
Name: system_client1_cpu_mult_seq

Overview:
Sequencing initiator for the CPU partial-product multiplier cell. It accepts a multiply request on a valid/ready handshake and drives operands plus an enable pulse into the cell. It captures the three 16x16 partial products the cell returns (p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo) and, for high-word ops, runs a second pass to obtain a_hi*b_hi. It then assembles the 32-bit result with signed correction and returns it on a valid/ready response port.

Parameters:
CELL_LATENCY, 1, cycles from the cell_en-qualified operand edge to the cell_p* outputs being valid; legal values are 1 and 2.

Ports:
clk  in  1  single clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_op  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS
req_src1  in  32  operand a
req_src2  in  32  operand b
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  result word
cell_src1  out  32  operand to multiplier cell
cell_src2  out  32  operand to multiplier cell
cell_en  out  1  cell pipeline enable, one-cycle pulse per pass
cell_p1  in  32  a_lo*b_lo from cell
cell_p2  in  32  a_lo*b_hi from cell
cell_p3  in  32  a_hi*b_lo from cell

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, cell_en 0, cell_src1/2 0, internal op/operand/partial regs 0. req_ready is 1 in the first cycle after reset.
- States: IDLE, PASS1, WAIT1, PASS2, WAIT2, RESP.
- IDLE: req_ready=1. If req_valid=1, latch op/src1/src2 and go to PASS1. In this state cell_p* are ignored.
- PASS1 (1 cycle): cell_src1=src1, cell_src2=src2, cell_en=1. Go to WAIT1.
- WAIT1 (CELL_LATENCY cycles, cell_en=0): on the last cycle, capture cell_p1/p2/p3.
  - MUL: load rsp_data = p1 + ((p2+p3)<<16) mod 2^32, go to RESP.
  - Other ops: go to PASS2.
- PASS2 (1 cycle): cell_src1={16'h0,src1[31:16]}, cell_src2={16'h0,src2[31:16]}, cell_en=1. Go to WAIT2.
- WAIT2 (CELL_LATENCY cycles): on the last cycle, capture p4 = cell_p1.
  - full = p1 + ((p2+p3)<<16) + (p4<<32), using 64-bit arithmetic with carries preserved; hi = full[63:32].
  - MULXSU: subtract src2 from hi if src1[31].
  - MULXSS: additionally subtract src1 from hi if src2[31].
  - All subtraction is mod 2^32. Load rsp_data = hi, go to RESP.
- RESP: rsp_valid=1. rsp_data is stable while rsp_ready=0. On rsp_ready=1, rsp_valid drops next cycle and the state returns to IDLE.
- Timing: a request accepted in cycle T gives rsp_valid in cycle T+2+CELL_LATENCY for MUL and T+3+2*CELL_LATENCY for high ops (T+3 / T+5 at default).
- cell_src1/2 hold their last driven value outside PASS states. cell_en is never high outside PASS states.
- No new request is accepted until the cycle after the response handshake; there is no overlap.
- Reset asserted in any state aborts the operation, with no response. Cell outputs arriving after reset are ignored.
- The 2-bit req_op is fully decoded; no illegal encodings exist.

Test Plan:
1. MUL 0x00010003 * 0x00020005 -> rsp_data 0x000B000F at T+3; exactly one cell_en pulse, at T+1.
2. MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> rsp_data 0xFFFFFFFE at T+5; two cell_en pulses, the second with cell_src1=cell_src2=0x0000FFFF.
3. Signed high words with src1=src2=0xFFFFFFFF:
   - MULXSS -> 0x00000000.
   - MULXSU -> 0xFFFFFFFF.
   - MULXSS 0x80000000 * 0x00000002 -> 0xFFFFFFFF.
   - MUL on the same operands -> 0x00000000.
4. Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> rsp_valid/rsp_data stable and req_ready=0 throughout; the second request is accepted the cycle after the response handshake.
5. Pulse reset during WAIT2 of a MULXSS -> next cycle rsp_valid=0, req_ready=1, cell_en=0, and no response is emitted; a following MUL 7*6 returns 0x0000002A with normal latency.
6. CELL_LATENCY=2 build: rerun scenarios 1 and 2 -> responses at T+4 and T+7 with identical data.
